// File: rtl/imem_boot_loader_if.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_if
// Bundles the byte-stream handshake and the instruction-memory write port
// used by imem_boot_loader.
//
// Signals:
//   in_valid   byte source has a byte on in_data
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle
//   imem_we    one-cycle instruction-memory write strobe
//   imem_addr  word-aligned byte address of the write (ADDR_W bits)
//   imem_wdata instruction word to write
//   dbg_state  current loader FSM state (observation only)
//
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready
// are both 1. The source holds in_data stable while in_valid is high and the
// byte has not been taken; in_ready does not depend on in_valid.
//
// Modports:
//   master  loader side (consumes the stream, drives the memory write port)
//   slave   environment side (byte source, memory, observer)
// -----------------------------------------------------------------------------
interface imem_boot_loader_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [2:0]        dbg_state;

   modport master (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata, dbg_state
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata, dbg_state
   );
endinterface

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Receives a program image as a big-endian byte stream (2-byte word count N,
// then N 4-byte words MSB first) and writes it word by word into the
// instruction memory. The processor is held in reset (cpu_hold=1) until the
// image has been fully loaded.
//
// Optional feature (macro IMEM_BOOT_CHECKSUM_EN): after the last data byte
// (or after the header when N=0) one extra byte is accepted and compared with
// the XOR of all header and data bytes; match -> DONE, mismatch -> ERROR.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   bus       imem_boot_loader_if.master: in_valid/in_data/in_ready stream,
//             imem_we/imem_addr/imem_wdata write port, dbg_state
//   cpu_hold  1 = keep processor in reset
//   done      image loaded successfully (sticky until reset)
//   error     load failed (sticky until reset)
//
// Parameters:
//   ADDR_W     byte-address width of the instruction memory; the memory holds
//              2^(ADDR_W-2) words. Must match the interface's ADDR_W.
//   BASE_ADDR  word-aligned byte address of the first word written
// -----------------------------------------------------------------------------
module imem_boot_loader #(
   parameter int          ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic               clk,
   input  logic               reset,
   imem_boot_loader_if.master bus,
   output logic               cpu_hold,
   output logic               done,
   output logic               error
);
   localparam logic [31:0]       MAX_WORDS = 32'd1 << (ADDR_W - 2);
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

   typedef enum logic [2:0] {
      ST_HDR_HI = 3'd0,
      ST_HDR_LO = 3'd1,
      ST_DATA   = 3'd2,
`ifdef IMEM_BOOT_CHECKSUM_EN
      ST_CHK    = 3'd3,
`endif
      ST_DONE   = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;

   // State reached once the last header/data byte has been taken, and
   // whether that state keeps accepting bytes.
`ifdef IMEM_BOOT_CHECKSUM_EN
   localparam state_t ST_END    = ST_CHK;
   localparam logic   END_READY = 1'b1;
`else
   localparam state_t ST_END    = ST_DONE;
   localparam logic   END_READY = 1'b0;
`endif

   state_t            state;
   logic              in_ready_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [15:0]       cnt;        // header word count, then words still to write
   logic [1:0]        byte_idx;   // byte position inside the current word
   logic [31:0]       word_q;     // word assembly shift register
`ifdef IMEM_BOOT_CHECKSUM_EN
   logic [7:0]        xor_q;      // running XOR of header and data bytes
`endif

   logic        xfer;
   logic [15:0] n_hdr;
   logic [31:0] word_next;

   assign xfer      = bus.in_valid & in_ready_q;
   assign n_hdr     = {cnt[15:8], bus.in_data};
   assign word_next = {word_q[23:0], bus.in_data};

   assign bus.in_ready   = in_ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.dbg_state  = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_HDR_HI;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= BASE;
         wdata_q    <= '0;
         cnt        <= '0;
         byte_idx   <= '0;
         word_q     <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         we_q <= 1'b0;

         // The cycle after a write strobe: move to the next word slot. The
         // next 4th byte is at least three cycles away, so this never races
         // with a new strobe.
         if (we_q) begin
            addr_q <= addr_q + ADDR_W'(4);
            cnt    <= cnt - 16'd1;
         end

`ifdef IMEM_BOOT_CHECKSUM_EN
         if (xfer && (state == ST_HDR_HI || state == ST_HDR_LO || state == ST_DATA))
            xor_q <= xor_q ^ bus.in_data;
`endif

         case (state)
            ST_HDR_HI: begin
               in_ready_q <= 1'b1;
               if (xfer) begin
                  cnt[15:8] <= bus.in_data;
                  state     <= ST_HDR_LO;
               end
            end

            ST_HDR_LO: begin
               in_ready_q <= 1'b1;
               if (xfer) begin
                  cnt[7:0] <= bus.in_data;
                  if (n_hdr == 16'd0) begin
                     state      <= ST_END;
                     in_ready_q <= END_READY;
                  end else if ({16'd0, n_hdr} > MAX_WORDS) begin
                     // Rejected before any write, so the address can never wrap.
                     state      <= ST_ERROR;
                     in_ready_q <= 1'b0;
                     error      <= 1'b1;
                  end else begin
                     state <= ST_DATA;
                  end
               end
            end

            ST_DATA: begin
               in_ready_q <= 1'b1;
               if (xfer) begin
                  word_q   <= word_next;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     we_q    <= 1'b1;
                     wdata_q <= word_next;
                     // cnt already reflects all earlier writes here.
                     if (cnt == 16'd1) begin
                        state      <= ST_END;
                        in_ready_q <= END_READY;
                     end
                  end
               end
            end

`ifdef IMEM_BOOT_CHECKSUM_EN
            ST_CHK: begin
               in_ready_q <= 1'b1;
               if (xfer) begin
                  in_ready_q <= 1'b0;
                  if (bus.in_data == xor_q) begin
                     state <= ST_DONE;
                  end else begin
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end
               end
            end
`endif

            ST_DONE: begin
               // Reached one edge after the last strobe was launched, so
               // done/cpu_hold change one cycle after that imem_we pulse.
               in_ready_q <= 1'b0;
               done       <= 1'b1;
               cpu_hold   <= 1'b0;
            end

            ST_ERROR: begin
               in_ready_q <= 1'b0;
               error      <= 1'b1;
               cpu_hold   <= 1'b1;
            end

            default: begin
               state      <= ST_ERROR;
               in_ready_q <= 1'b0;
               error      <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed stimulus for imem_boot_loader. A stream-level model turns each
// byte stream into the list of memory writes and the final outcome; a
// monitor compares every write and the hold/done relation each cycle.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;
   localparam int          ADDR_W    = 10;
   localparam int unsigned BASE_ADDR = 0;
   localparam int          W         = ADDR_W + 32;
   localparam int          MAX_WORDS = 1 << (ADDR_W - 2);

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic cpu_hold;
   logic done;
   logic error;

   always #5 clk = ~clk;

   imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_boot_loader #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.master),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0]      exp_q[$];
   logic [7:0]        stim_q[$];
   int                n_cmp = 0;
   int                n_bad = 0;
   int                cyc = 0;
   bit                mon_en = 1'b0;
   int                we_count = 0;
   int                last_we_cyc = -1;
   int                done_rise_cyc = -1;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [31:0]       last_data = '0;
   bit                exp_done;
   bit                exp_err;
   logic              prev_we = 1'b0;
   logic              prev_done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      forever @(posedge clk) cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stream-level model ----------------
   // Parses stim_q as the loader's input format and queues the writes that
   // must appear, plus whether the load must end in done or error.
   task automatic model_build();
      int         nb;
      int         n;
      int         b;
      logic [7:0] x;
      nb       = stim_q.size();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      x        = 8'h00;
      if (nb < 2) return;
      n = int'({stim_q[0], stim_q[1]});
      if (n > MAX_WORDS) begin
         exp_err = 1'b1;
         return;
      end
      for (int k = 0; k < n; k++) begin
         b = 2 + 4 * k;
         if (b + 3 < nb)
            exp_q.push_back({ADDR_W'(BASE_ADDR + 4 * k),
                             stim_q[b], stim_q[b+1], stim_q[b+2], stim_q[b+3]});
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      if (nb == 2 + 4 * n + 1) begin
         for (int i = 0; i < nb - 1; i++) x ^= stim_q[i];
         if (stim_q[nb-1] == x) exp_done = 1'b1;
         else                   exp_err  = 1'b1;
      end
`else
      if (nb >= 2 + 4 * n) exp_done = 1'b1;
`endif
   endtask

   // ---------------- monitor / compare process ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("hold_vs_done", 64'(cpu_hold), 64'(!done));
            if (bus.imem_we === 1'b1) begin
               check("we_single_cycle", 64'(prev_we), 64'd0);
               we_count++;
               last_we_cyc = cyc;
               last_addr   = bus.imem_addr;
               last_data   = bus.imem_wdata;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                           bus.imem_addr, bus.imem_wdata);
               end else begin
                  check("write_addr_data", 64'({bus.imem_addr, bus.imem_wdata}),
                        64'(exp_q.pop_front()));
               end
            end
            if (done === 1'b1 && prev_done === 1'b0) done_rise_cyc = cyc;
            prev_we   = bus.imem_we;
            prev_done = done;
         end else begin
            prev_we   = 1'b0;
            prev_done = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      reset        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      check("rst_in_ready",   64'(bus.in_ready),   64'd0);
      check("rst_imem_we",    64'(bus.imem_we),    64'd0);
      check("rst_imem_addr",  64'(bus.imem_addr),  64'(BASE_ADDR));
      check("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
      check("rst_cpu_hold",   64'(cpu_hold),       64'd1);
      check("rst_done",       64'(done),           64'd0);
      check("rst_error",      64'(error),          64'd0);
      exp_q.delete();
      reset = 1'b1;
      #1;
      check("ready_before_first_clk", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("ready_after_first_clk", 64'(bus.in_ready), 64'd1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard        = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: byte 0x%0h not taken, in_ready=%0b required 1", b, bus.in_ready);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Sends stim_q (optionally with an idle cycle after each byte) and checks
   // the outcome against the model.
   task automatic run_stream(input string name, input bit gap);
      model_build();
      we_count      = 0;
      last_we_cyc   = -1;
      done_rise_cyc = -1;
      foreach (stim_q[i]) begin
         send_byte(stim_q[i]);
         if (gap) begin
            @(posedge clk);
            #1;
         end
      end
      repeat (4) @(posedge clk);
      #1;
      check({name, ".done"},     64'(done),         64'(exp_done));
      check({name, ".error"},    64'(error),        64'(exp_err));
      check({name, ".cpu_hold"}, 64'(cpu_hold),     64'(!exp_done));
      check({name, ".in_ready"}, 64'(bus.in_ready), 64'(!(exp_done || exp_err)));
      check({name, ".pending"},  64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      // Single word at one byte per cycle.
      do_reset();
      stim_q = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
`ifdef IMEM_BOOT_CHECKSUM_EN
      stim_q.push_back(8'h2C);
`endif
      run_stream("one_word", 1'b0);
      check("one_word.count", 64'(we_count),  64'd1);
      check("one_word.addr",  64'(last_addr), 64'h000);
      check("one_word.data",  64'(last_data), 64'h20080005);
`ifndef IMEM_BOOT_CHECKSUM_EN
      check("one_word.done_lag", 64'(done_rise_cyc), 64'(last_we_cyc + 1));
`endif

      // Bytes offered after DONE are ignored.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      repeat (4) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("after_done.count", 64'(we_count), 64'd1);
      check("after_done.done",  64'(done),     64'd1);

      // Three words with in_valid toggling every other cycle.
      do_reset();
      stim_q = '{8'h00, 8'h03,
                 8'h11, 8'h11, 8'h11, 8'h11,
                 8'h22, 8'h22, 8'h22, 8'h22,
                 8'h33, 8'h33, 8'h33, 8'h33};
`ifdef IMEM_BOOT_CHECKSUM_EN
      stim_q.push_back(8'h03);
`endif
      run_stream("three_words", 1'b1);
      check("three_words.count", 64'(we_count),  64'd3);
      check("three_words.addr",  64'(last_addr), 64'h008);
      check("three_words.data",  64'(last_data), 64'h33333333);

      // Oversized header: 257 words > 256.
      do_reset();
      stim_q = '{8'h01, 8'h01};
      run_stream("too_big", 1'b0);
      check("too_big.count", 64'(we_count), 64'd0);
      check("too_big.error", 64'(error),    64'd1);

      // Empty image.
      do_reset();
      stim_q = '{8'h00, 8'h00};
`ifdef IMEM_BOOT_CHECKSUM_EN
      stim_q.push_back(8'h00);
`endif
      run_stream("empty", 1'b0);
      check("empty.count", 64'(we_count), 64'd0);
      check("empty.done",  64'(done),     64'd1);

      // Reset after two data bytes, then a full load.
      do_reset();
      stim_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
      run_stream("partial", 1'b0);
      reset = 1'b0;
      #1;
      check("abort.imem_we",  64'(bus.imem_we),  64'd0);
      check("abort.cpu_hold", 64'(cpu_hold),     64'd1);
      check("abort.in_ready", 64'(bus.in_ready), 64'd0);
      do_reset();
      stim_q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_BOOT_CHECKSUM_EN
      stim_q.push_back(8'h01);
`endif
      run_stream("reload", 1'b0);
      check("reload.count", 64'(we_count),  64'd1);
      check("reload.addr",  64'(last_addr), 64'h000);
      check("reload.data",  64'(last_data), 64'hAABBCCDD);

`ifdef IMEM_BOOT_CHECKSUM_EN
      // Checksum match and mismatch.
      do_reset();
      stim_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
      run_stream("chk_ok", 1'b0);
      check("chk_ok.done", 64'(done),      64'd1);
      check("chk_ok.data", 64'(last_data), 64'h12345678);

      do_reset();
      stim_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
      run_stream("chk_bad", 1'b0);
      check("chk_bad.error", 64'(error),    64'd1);
      check("chk_bad.hold",  64'(cpu_hold), 64'd1);
      check("chk_bad.count", 64'(we_count), 64'd1);
`endif

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
